ps2_rx_frame: RTL and testbench

Receives the raw PS/2 keyboard serial stream (device-to-host only) and delivers each scan-code byte with a one-cycle strobe. It sits directly upstream of the scan-code-to-ASCII translator: its `ps2_code` and `ps2_code_new` outputs drive that stage's inputs unchanged. It synchronises and glitch-filters the asynchronous PS/2 lines, frames 11-bit packets, checks parity and stop bit, and aborts stalled frames.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_line_filter.sv | 54 +++++
 rtl/ps2_rx_frame.sv | 129 ++++++++++++
 tb/tb_ps2_rx_frame.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states and scan-code constants
// also used by the downstream scan-code translator.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [7:0]  PS2_BREAK      = 8'hF0;
  localparam logic [7:0]  PS2_EXT        = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises an asynchronous PS/2 line, rejects glitches shorter than
// FILTER_LEN samples and emits a registered one-cycle falling-edge pulse.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          clk_f_q, clk_f_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          fall_q,  fall_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    clk_f_d = clk_f_q;
    cnt_d   = '0;
    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    if (sync2_q != clk_f_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        clk_f_d = ~clk_f_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = clk_f_q & ~clk_f_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      clk_f_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clk_f_q <= clk_f_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: frames 11-bit packets, checks odd
// parity and stop bit, aborts stalled frames, strobes out each good byte.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_code,
  output logic       ps2_code_new,
  output logic       ps2_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic fall;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk),
    .fall    (fall)
  );

  logic          dsync1_q,   dsync1_d;
  logic          dsync2_q,   dsync2_d;
  ps2_state_e    state_q,    state_d;
  logic [2:0]    bit_cnt_q,  bit_cnt_d;
  logic [7:0]    shreg_q,    shreg_d;
  logic          par_q,      par_d;
  logic [TW-1:0] tmo_q,      tmo_d;
  logic [7:0]    code_q,     code_d;
  logic          code_new_q, code_new_d;
  logic          err_q,      err_d;

  always_comb begin
    dsync1_d   = ps2_data;
    dsync2_d   = dsync1_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    code_d     = code_q;
    code_new_d = 1'b0;
    err_d      = 1'b0;

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dsync2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {dsync2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = dsync2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dsync2_q && ((^shreg_q) ^ par_q)) begin
            code_d     = shreg_q;
            code_new_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A fall in the same cycle as expiry wins: the frame keeps going.
    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsync1_q   <= 1'b1;
      dsync2_q   <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      code_q     <= '0;
      code_new_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dsync1_q   <= dsync1_d;
      dsync2_q   <= dsync2_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      code_q     <= code_d;
      code_new_q <= code_new_d;
      err_q      <= err_d;
    end
  end

  assign ps2_code     = code_q;
  assign ps2_code_new = code_new_q;
  assign ps2_err      = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: drives PS/2 frames, glitches, stalls and
// resets, and checks strobes and captured codes against hand-computed values.
module tb_ps2_rx_frame;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 300;
  localparam int          HALF = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_code;
  logic       ps2_code_new;
  logic       ps2_err;

  ps2_rx_frame #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .ps2_code     (ps2_code),
    .ps2_code_new (ps2_code_new),
    .ps2_err      (ps2_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int new_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] code_log[$];

  always @(negedge clk) begin
    if (ps2_code_new) begin
      new_cnt++;
      code_log.push_back(ps2_code);
    end
    if (ps2_err) err_cnt++;
    if (ps2_code_new && ps2_err) both_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a frame; flip inverts the parity bit,
  // glitch adds a 3-cycle low pulse in each bit's high phase.
  task automatic send_frame(input logic [7:0] b, input logic flip,
                            input int nbits, input logic glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cyc(HALF / 2);
      if (glitch) begin
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(HALF / 2 - 3);
      end else begin
        cyc(HALF / 2);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(5);
    vecs++; if (ps2_code !== 8'h00) begin errs++; $display("FAIL reset_code got=%h exp=00", ps2_code); end
    vecs++; if (ps2_code_new !== 1'b0) begin errs++; $display("FAIL reset_new got=%b exp=0", ps2_code_new); end
    vecs++; if (ps2_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", ps2_err); end
    rst = 1'b0;
    cyc(20);
  endtask

  task automatic test_single();
    int n0, e0;
    n0 = new_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    vecs++; if (new_cnt - n0 !== 1) begin errs++; $display("FAIL single_pulses got=%0d exp=1", new_cnt - n0); end
    vecs++; if (err_cnt - e0 !== 0) begin errs++; $display("FAIL single_err got=%0d exp=0", err_cnt - e0); end
    vecs++; if (ps2_code !== 8'h1C) begin errs++; $display("FAIL single_code got=%h exp=1c", ps2_code); end
  endtask

  task automatic test_back_to_back();
    int n0, e0;
    n0 = new_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    vecs++; if (new_cnt - n0 !== 2) begin errs++; $display("FAIL b2b_pulses got=%0d exp=2", new_cnt - n0); end
    vecs++; if (err_cnt - e0 !== 0) begin errs++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0); end
    if (code_log.size() >= 2) begin
      vecs++; if (code_log[code_log.size()-2] !== 8'hF0) begin errs++; $display("FAIL b2b_first got=%h exp=f0", code_log[code_log.size()-2]); end
      vecs++; if (code_log[code_log.size()-1] !== 8'h1C) begin errs++; $display("FAIL b2b_second got=%h exp=1c", code_log[code_log.size()-1]); end
    end else begin
      vecs++; errs++; $display("FAIL b2b_log got=%0d entries exp>=2", code_log.size());
    end
  endtask

  task automatic test_parity_err();
    int n0, e0;
    n0 = new_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    vecs++; if (err_cnt - e0 !== 1) begin errs++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
    vecs++; if (new_cnt - n0 !== 0) begin errs++; $display("FAIL parity_new got=%0d exp=0", new_cnt - n0); end
    vecs++; if (ps2_code !== 8'h1C) begin errs++; $display("FAIL parity_hold got=%h exp=1c", ps2_code); end
  endtask

  task automatic test_glitch();
    int n0, e0;
    n0 = new_cnt; e0 = err_cnt;
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(20);
    end
    vecs++; if (new_cnt - n0 !== 0 || err_cnt - e0 !== 0) begin errs++; $display("FAIL glitch_idle got new=%0d err=%0d exp 0/0", new_cnt - n0, err_cnt - e0); end
    send_frame(8'h5A, 1'b0, 11, 1'b1);
    vecs++; if (new_cnt - n0 !== 1) begin errs++; $display("FAIL glitch_pulses got=%0d exp=1", new_cnt - n0); end
    vecs++; if (err_cnt - e0 !== 0) begin errs++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - e0); end
    vecs++; if (ps2_code !== 8'h5A) begin errs++; $display("FAIL glitch_code got=%h exp=5a", ps2_code); end
  endtask

  task automatic test_timeout();
    int n0, e0;
    n0 = new_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b0, 5, 1'b0);
    vecs++; if (err_cnt - e0 !== 0) begin errs++; $display("FAIL tmo_early got=%0d exp=0", err_cnt - e0); end
    cyc(TMO + 5);
    vecs++; if (err_cnt - e0 !== 1) begin errs++; $display("FAIL tmo_err got=%0d exp=1", err_cnt - e0); end
    vecs++; if (new_cnt - n0 !== 0) begin errs++; $display("FAIL tmo_new got=%0d exp=0", new_cnt - n0); end
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 11, 1'b0);
    vecs++; if (ps2_code !== 8'h29) begin errs++; $display("FAIL tmo_next_code got=%h exp=29", ps2_code); end
    vecs++; if (new_cnt - n0 !== 1 || err_cnt - e0 !== 0) begin errs++; $display("FAIL tmo_next_pulses got new=%0d err=%0d exp 1/0", new_cnt - n0, err_cnt - e0); end
  endtask

  task automatic test_reset_midframe();
    int n0, e0;
    n0 = new_cnt; e0 = err_cnt;
    send_frame(8'h42, 1'b0, 7, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(30);
    vecs++; if (ps2_code !== 8'h00) begin errs++; $display("FAIL rstmid_code got=%h exp=00", ps2_code); end
    vecs++; if (new_cnt - n0 !== 0 || err_cnt - e0 !== 0) begin errs++; $display("FAIL rstmid_pulses got new=%0d err=%0d exp 0/0", new_cnt - n0, err_cnt - e0); end
    send_frame(8'h76, 1'b0, 11, 1'b0);
    vecs++; if (ps2_code !== 8'h76) begin errs++; $display("FAIL rstmid_next_code got=%h exp=76", ps2_code); end
    vecs++; if (new_cnt - n0 !== 1 || err_cnt - e0 !== 0) begin errs++; $display("FAIL rstmid_next_pulses got new=%0d err=%0d exp 1/0", new_cnt - n0, err_cnt - e0); end
  endtask

  task automatic test_exclusive();
    vecs++; if (both_cnt !== 0) begin errs++; $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    cyc(2);
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_err();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
